// File: rtl/idli_pkg.sv
// Shared types, widths and command codes for the SQI memory controller.
package idli_pkg;

  localparam int unsigned SQI_DATA_W = 16;
  localparam int unsigned SQI_NIB_W  = 4;
  localparam int unsigned SQI_CNT_W  = 3;

  typedef enum logic {
    SQI_IO_MODE_IN  = 1'b0,
    SQI_IO_MODE_OUT = 1'b1
  } sqi_io_mode_t;

  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_ESQI  = 8'h38;

  typedef enum logic [2:0] {
    SQI_ST_INIT,
    SQI_ST_IDLE,
    SQI_ST_CMD,
    SQI_ST_ADDR,
    SQI_ST_DUMMY,
    SQI_ST_DATA,
    SQI_ST_GAP,
    SQI_ST_RSP
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI serial memory controller: 16-bit core reads/writes over a quad-SPI link.
// Optional IDLI_SQI_ESQI_EN: after reset, send 0x38 (enter quad mode) in 1-bit SPI mode.
module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_req_vld,
  output logic        o_sqi_req_acp,
  input  logic        i_sqi_req_wr,
  input  logic [15:0] i_sqi_req_addr,
  input  logic [15:0] i_sqi_req_data,
  output logic        o_sqi_rsp_vld,
  output logic [15:0] o_sqi_rsp_data,
  input  logic        i_sqi_rsp_acp,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output logic        o_sqi_io_mode,
  input  logic [3:0]  i_sqi_sio,
  output logic [3:0]  o_sqi_sio
);

`ifdef IDLI_SQI_ESQI_EN
  localparam sqi_state_t                RST_STATE = SQI_ST_INIT;
  localparam logic [SQI_DATA_W-1:0] RST_SHIFT = {SQI_CMD_ESQI, 8'h00};
`else
  localparam sqi_state_t                RST_STATE = SQI_ST_IDLE;
  localparam logic [SQI_DATA_W-1:0] RST_SHIFT = '0;
`endif

  sqi_state_t            state, state_nxt;
  logic                  phase, phase_nxt;
  logic [SQI_CNT_W-1:0]  cnt, cnt_nxt;
  logic [SQI_DATA_W-1:0] shift, shift_nxt;
  logic                  wr, wr_nxt;
  logic [SQI_DATA_W-1:0] addr, addr_nxt;
  logic [SQI_DATA_W-1:0] data, data_nxt;
  logic [SQI_DATA_W-1:0] rsp_data, rsp_data_nxt;

  logic                  active;
  logic                  last;
  logic                  sck;
  logic                  cs;
  sqi_io_mode_t          io_mode;
  logic [SQI_NIB_W-1:0]  sio;
  logic                  req_acp;
  logic                  rsp_vld;

  // State and datapath registers
  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state    <= RST_STATE;
      phase    <= 1'b0;
      cnt      <= '0;
      shift    <= RST_SHIFT;
      wr       <= 1'b0;
      addr     <= '0;
      data     <= '0;
      rsp_data <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      shift    <= shift_nxt;
      wr       <= wr_nxt;
      addr     <= addr_nxt;
      data     <= data_nxt;
      rsp_data <= rsp_data_nxt;
    end
  end

  // Next-state, datapath and pin decode
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    cnt_nxt      = cnt;
    shift_nxt    = shift;
    wr_nxt       = wr;
    addr_nxt     = addr;
    data_nxt     = data;
    rsp_data_nxt = rsp_data;
    active       = 1'b0;
    last         = 1'b0;
    sck          = 1'b0;
    cs           = 1'b1;
    io_mode      = SQI_IO_MODE_OUT;
    sio          = '0;
    req_acp      = 1'b0;
    rsp_vld      = 1'b0;

    case (state)
`ifdef IDLI_SQI_ESQI_EN
      SQI_ST_INIT: begin
        active = 1'b1;
        sio    = {3'b000, shift[SQI_DATA_W-1]};
        if (phase) begin
          shift_nxt = {shift[SQI_DATA_W-2:0], 1'b0};
          last      = (cnt == 3'd7);
        end
        if (last) state_nxt = SQI_ST_GAP;
      end
`endif
      SQI_ST_IDLE: begin
        req_acp = i_sqi_req_vld;
        if (i_sqi_req_vld) begin
          wr_nxt    = i_sqi_req_wr;
          addr_nxt  = i_sqi_req_addr;
          data_nxt  = i_sqi_req_data;
          shift_nxt = {(i_sqi_req_wr ? SQI_CMD_WRITE : SQI_CMD_READ), 8'h00};
          phase_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = SQI_ST_CMD;
        end
      end
      SQI_ST_CMD: begin
        active = 1'b1;
        sio    = shift[SQI_DATA_W-1 -: SQI_NIB_W];
        if (phase) begin
          shift_nxt = {shift[SQI_DATA_W-SQI_NIB_W-1:0], 4'h0};
          last      = (cnt == 3'd1);
        end
        if (last) begin
          shift_nxt = addr;
          state_nxt = SQI_ST_ADDR;
        end
      end
      SQI_ST_ADDR: begin
        active = 1'b1;
        sio    = shift[SQI_DATA_W-1 -: SQI_NIB_W];
        if (phase) begin
          shift_nxt = {shift[SQI_DATA_W-SQI_NIB_W-1:0], 4'h0};
          last      = (cnt == 3'd3);
        end
        if (last) begin
          shift_nxt = wr ? data : '0;
          state_nxt = wr ? SQI_ST_DATA : SQI_ST_DUMMY;
        end
      end
      SQI_ST_DUMMY: begin
        active  = 1'b1;
        io_mode = SQI_IO_MODE_IN;
        if (phase) last = (cnt == 3'd1);
        if (last) state_nxt = SQI_ST_DATA;
      end
      SQI_ST_DATA: begin
        active = 1'b1;
        if (wr) begin
          sio = shift[SQI_DATA_W-1 -: SQI_NIB_W];
          if (phase) shift_nxt = {shift[SQI_DATA_W-SQI_NIB_W-1:0], 4'h0};
        end else begin
          io_mode = SQI_IO_MODE_IN;
          if (phase) shift_nxt = {shift[SQI_DATA_W-SQI_NIB_W-1:0], i_sqi_sio};
        end
        if (phase) last = (cnt == 3'd3);
        if (last) begin
          state_nxt = wr ? SQI_ST_GAP : SQI_ST_RSP;
          if (!wr) rsp_data_nxt = {shift[SQI_DATA_W-SQI_NIB_W-1:0], i_sqi_sio};
        end
      end
      SQI_ST_GAP: state_nxt = SQI_ST_IDLE;
      SQI_ST_RSP: begin
        rsp_vld = 1'b1;
        if (i_sqi_rsp_acp) state_nxt = SQI_ST_IDLE;
      end
      default: state_nxt = SQI_ST_IDLE;
    endcase

    // Shared two-phase nibble timing for every state that drives the link
    if (active) begin
      cs        = 1'b0;
      sck       = phase;
      phase_nxt = ~phase;
      if (phase) cnt_nxt = last ? '0 : SQI_CNT_W'(cnt + 3'd1);
    end

    // Reset forces the pins quiet even in states that would otherwise drive them
    if (i_sqi_rst) begin
      sck     = 1'b0;
      cs      = 1'b1;
      io_mode = SQI_IO_MODE_OUT;
      sio     = '0;
      req_acp = 1'b0;
      rsp_vld = 1'b0;
    end
  end

  assign o_sqi_req_acp  = req_acp;
  assign o_sqi_rsp_vld  = rsp_vld;
  assign o_sqi_rsp_data = rsp_data;
  assign o_sqi_sck      = sck;
  assign o_sqi_cs       = cs;
  assign o_sqi_io_mode  = io_mode;
  assign o_sqi_sio      = sio;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: random core traffic against a byte-array SQI memory model.
// Define IDLI_SQI_ESQI_EN to also check the post-reset enter-quad-mode sequence.
module tb_idli_sqi_ctrl_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_acp;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic        rsp_vld;
  logic [15:0] rsp_data;
  logic        rsp_acp = 1'b0;
  logic        sck;
  logic        cs;
  logic        io_mode;
  logic [3:0]  sio_in = '0;
  logic [3:0]  sio_out;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0] mem [int unsigned];

  idli_sqi_ctrl_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst      (rst),
    .i_sqi_req_vld  (req_vld),
    .o_sqi_req_acp  (req_acp),
    .i_sqi_req_wr   (req_wr),
    .i_sqi_req_addr (req_addr),
    .i_sqi_req_data (req_data),
    .o_sqi_rsp_vld  (rsp_vld),
    .o_sqi_rsp_data (rsp_data),
    .i_sqi_rsp_acp  (rsp_acp),
    .o_sqi_sck      (sck),
    .o_sqi_cs       (cs),
    .o_sqi_io_mode  (io_mode),
    .i_sqi_sio      (sio_in),
    .o_sqi_sio      (sio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {mem_byte(a), mem_byte(16'(a + 16'd1))};
  endfunction

  // One full core transaction; starts and ends in a cycle where the DUT is idle
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int unsigned hold);
    logic [63:0] nib = '0;
    logic [15:0] rd_exp = '0;
    logic [15:0] rd_drv = '0;
    logic [15:0] rsp_prev;
    logic [15:0] rsp_hold = '0;
    int unsigned n_nib = 0, cs_cnt = 0, cs_first = 0, cs_last = 0, sck_hi = 0;
    int unsigned in_cnt = 0, in_first = 0, acp_bad = 0, sck_bad = 0, stab_bad = 0, rsp_first = 0;
    logic done = 1'b0;
    rsp_prev = rsp_data;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_data = wdata;
    #1;
    check("accept", 64'(req_acp), 64'd1);
    if (wr) begin
      mem[32'(addr)] = wdata[15:8];
      mem[32'(16'(addr + 16'd1))] = wdata[7:0];
    end else begin
      rd_exp = mem_word(addr);
    end
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (!cs && io_mode == 1'b0 && in_cnt >= 4 && in_cnt < 12) begin
        if (!sck) sio_in = 4'(rd_drv >> (4 * (3 - (in_cnt - 4) / 2)));
      end else begin
        sio_in = 4'($urandom);
      end
      if (!cs) begin
        cs_cnt++;
        if (cs_first == 0) cs_first = c;
        cs_last = c;
        if (sck) sck_hi++;
        if (io_mode == 1'b0) begin
          if (in_first == 0) in_first = c;
          in_cnt++;
        end else if (sck) begin
          nib = {nib[59:0], sio_out};
          n_nib++;
          if (n_nib == 6) rd_drv = mem_word(nib[15:0]);
        end
      end else if (sck) begin
        sck_bad++;
      end
      if (rsp_vld) begin
        if (rsp_first == 0) begin rsp_first = c; rsp_hold = rsp_data; end
        else if (rsp_data !== rsp_hold) stab_bad++;
      end else if (rsp_first != 0 && c <= rsp_first + hold) begin
        stab_bad++;
      end
      req_vld = 1'b1; req_wr = 1'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
      rsp_acp = (rsp_first != 0) ? (c >= rsp_first + hold) : 1'($urandom);
      done = wr ? (c == 22) : (rsp_first != 0 && c == rsp_first + hold + 1);
      #1;
      if (done) check(wr ? "wr_reaccept" : "rd_reaccept", 64'(req_acp), 64'd1);
      else if (req_acp) acp_bad++;
    end
    req_vld = 1'b0; rsp_acp = 1'b0; sio_in = '0;
    check("n_nibbles", 64'(n_nib), wr ? 64'd10 : 64'd6);
    check("nibbles", nib, wr ? 64'({8'h02, addr, wdata}) : 64'({8'h03, addr}));
    check("cs_cycles", 64'(cs_cnt), wr ? 64'd20 : 64'd24);
    check("cs_first", 64'(cs_first), 64'd1);
    check("cs_last", 64'(cs_last), wr ? 64'd20 : 64'd24);
    check("sck_periods", 64'(sck_hi), wr ? 64'd10 : 64'd12);
    check("in_cycles", 64'(in_cnt), wr ? 64'd0 : 64'd12);
    check("in_first", 64'(in_first), wr ? 64'd0 : 64'd13);
    check("sck_idle", 64'(sck_bad), 64'd0);
    check("acp_busy", 64'(acp_bad), 64'd0);
    if (wr) begin
      check("wr_rsp_keep", 64'(rsp_data), 64'(rsp_prev));
    end else begin
      check("rsp_cycle", 64'(rsp_first), 64'd25);
      check("rsp_data", 64'(rsp_hold), 64'(rd_exp));
      check("rsp_stable", 64'(stab_bad), 64'd0);
    end
  endtask

  // Called in the cycle reset is released
  task automatic post_reset();
`ifdef IDLI_SQI_ESQI_EN
    logic [7:0] bits = '0;
    int unsigned n_bits = 0, cs_cnt = 0, hi_bad = 0;
    int idle_at = -1;
    req_vld = 1'b1;
    for (int c = 0; c < 40 && idle_at < 0; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (!cs) begin
        cs_cnt++;
        if (sio_out[3:1] != 3'b000) hi_bad++;
        if (sck) begin bits = {bits[6:0], sio_out[0]}; n_bits++; end
      end
      if (req_acp) idle_at = c;
    end
    req_vld = 1'b0;
    check("esqi_bits", 64'(bits), 64'h38);
    check("esqi_nbits", 64'(n_bits), 64'd8);
    check("esqi_cs", 64'(cs_cnt), 64'd16);
    check("esqi_sio_hi", 64'(hi_bad), 64'd0);
    check("esqi_idle_at", 64'(idle_at), 64'd17);
`else
    int unsigned sck_hi = 0, cs_lo = 0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (sck) sck_hi++;
      if (!cs) cs_lo++;
    end
    check("quiet_sck", 64'(sck_hi), 64'd0);
    check("quiet_cs", 64'(cs_lo), 64'd0);
    req_vld = 1'b1;
    #1;
    check("idle_after_rst", 64'(req_acp), 64'd1);
    req_vld = 1'b0;
`endif
  endtask

  initial begin
    logic [15:0] a;
    req_vld = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_io", 64'(io_mode), 64'd1);
    check("rst_sio", 64'(sio_out), 64'd0);
    check("rst_acp", 64'(req_acp), 64'd0);
    check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    req_vld = 1'b0;
    rst = 1'b0;
    post_reset();

    mem[32'h00FF] = 8'hCA;
    mem[32'h0100] = 8'hFE;
    run_txn(1'b1, 16'h1234, 16'hBEEF, 0);
    run_txn(1'b0, 16'h00FF, 16'h0000, 0);
    run_txn(1'b0, 16'h1234, 16'h0000, 10);
    run_txn(1'b1, 16'hFFFF, 16'h1357, 0);
    run_txn(1'b0, 16'hFFFF, 16'h0000, 2);

    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 1) == 0) ? {12'h0A0, 4'($urandom_range(0, 7))} : 16'($urandom);
      run_txn(1'($urandom), a, 16'($urandom), $urandom_range(0, 4));
    end

    // Reset in the middle of a write
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0F0F; req_data = 16'hA5A5;
    #1;
    check("abort_accept", 64'(req_acp), 64'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_vld = 1'b0;
    end
    #1;
    check("abort_cs_before", 64'(cs), 64'd0);
    rst = 1'b1;
    req_vld = 1'b1;
    #1;
    check("abort_cs", 64'(cs), 64'd1);
    check("abort_sck", 64'(sck), 64'd0);
    check("abort_io", 64'(io_mode), 64'd1);
    check("abort_sio", 64'(sio_out), 64'd0);
    check("abort_acp", 64'(req_acp), 64'd0);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    rst = 1'b0;
    post_reset();
    run_txn(1'b0, 16'h1234, 16'h0000, 1);
    run_txn(1'b1, 16'h0F0F, 16'h5A5A, 0);
    run_txn(1'b0, 16'h0F0F, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
IDLI_SQI_CTRL_M -- requirements
Module: idli_sqi_ctrl_m

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 SHALL have ports (name direction width meaning):
- i_sqi_gck  in  1  clock; all state updates on rising edge
- i_sqi_rst  in  1  asynchronous reset, active-high
- i_sqi_req_vld  in  1  core request valid
- o_sqi_req_acp  out  1  request accepted this cycle
- i_sqi_req_wr  in  1  1 = write, 0 = read
- i_sqi_req_addr  in  16  byte address
- i_sqi_req_data  in  16  write data
- o_sqi_rsp_vld  out  1  read data valid
- o_sqi_rsp_data  out  16  read data
- i_sqi_rsp_acp  in  1  core accepts read data
- o_sqi_sck  out  1  SQI serial clock
- o_sqi_cs  out  1  SQI chip select, active-low
- o_sqi_io_mode  out  1  sio direction (sqi_io_mode_t)
- i_sqi_sio  in  4  SQI data from memory
- o_sqi_sio  out  4  SQI data to memory

Function
REQ-003 SHALL implement states INIT, IDLE, CMD, ADDR, DUMMY, DATA, GAP, RSP.
REQ-004 SHALL assert o_sqi_req_acp only in IDLE with i_sqi_req_vld high and reset low; acceptance latches wr, addr and data and moves to CMD.
REQ-005 SHALL send every nibble over 2 gck cycles: phase 0 sck=0 with o_sqi_sio driven; phase 1 sck=1 with the same nibble held.
REQ-006 SHALL hold o_sqi_cs low from CMD through DATA inclusive, and high in every other state.
REQ-007 CMD SHALL send 2 nibbles, MSB first: 0x02 for write, 0x03 for read.
REQ-008 ADDR SHALL send 4 nibbles of i_sqi_req_addr, MSB nibble first.
REQ-009 DUMMY (reads only) SHALL last 2 nibble times with o_sqi_io_mode=IN and o_sqi_sio=0.
REQ-010 Write DATA SHALL send 4 nibbles, MSB first: the high byte goes to addr, the low byte to addr+1.
REQ-011 Read DATA SHALL keep io_mode=IN and shift i_sqi_sio into the result MSB first, sampled on the gck edge that ends phase 1.
REQ-012 io_mode SHALL be OUT in every state except DUMMY and read DATA.
REQ-013 After a write, GAP SHALL hold cs high for exactly 1 cycle, then go to IDLE.
REQ-014 After a read, RSP SHALL hold o_sqi_rsp_vld high with o_sqi_rsp_data stable until i_sqi_rsp_acp is sampled high, then go to IDLE; no request is accepted in RSP.
REQ-015 Latency, with acceptance at cycle 0:
- write: cs low for cycles 1-20; next acceptance possible at cycle 22
- read: cs low for cycles 1-24; rsp_vld first high at cycle 25
REQ-016 o_sqi_rsp_data SHALL update only on read completion.
REQ-017 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-018 On i_sqi_rst, including mid-transaction, SHALL immediately force:
- sck=0, cs=1, io_mode=OUT, sio=0
- req_acp=0, rsp_vld=0, rsp_data=0
- state=INIT with IDLI_SQI_ESQI_EN defined, else IDLE
REQ-019 A transaction aborted by reset SHALL NOT be resumed.

Configuration
REQ-020 With macro IDLI_SQI_ESQI_EN defined, INIT SHALL send 0x38 (enter quad mode) in single-bit SPI mode:
- MSB first on o_sqi_sio[0], other bits 0
- 8 sck periods of 2 gck each, cs low for 16 cycles
- then GAP, then IDLE
REQ-021 Without IDLI_SQI_ESQI_EN, INIT SHALL be absent and reset SHALL go directly to IDLE.

Structure
REQ-022 idli_pkg SHALL hold:
- sqi_io_mode_t (SQI_IO_MODE_IN=0, SQI_IO_MODE_OUT=1)
- SQI_CMD_WRITE=8'h02, SQI_CMD_READ=8'h03, SQI_CMD_ESQI=8'h38
- the state enum
REQ-023 SHALL be a single module with one 16-bit shift register, a 3-bit nibble counter and a phase bit; no sub-module.

Verification
REQ-024 Write addr=0x1234 data=0xBEEF -> sio nibbles 0,2,1,2,3,4,B,E,E,F; cs low for 20 cycles; acp pulses once.
REQ-025 Read addr=0x00FF with the model returning 0xCAFE -> sio nibbles 0,3,0,0,F,F; io_mode IN for 12 cycles; rsp_data=0xCAFE with rsp_vld at cycle 25.
REQ-026 rsp_acp held low for 10 cycles with req_vld high -> rsp_vld and rsp_data stable, req_acp stays 0; acp accepted -> next request accepted.
REQ-027 Reset asserted at cycle 7 of a write -> cs=1, sck=0, io_mode=OUT in the same cycle; no further sck edges until a new request.
REQ-028 IDLI_SQI_ESQI_EN defined, reset released -> sio[0] serialises 0,0,1,1,1,0,0,0 over 8 sck periods; req_acp stays 0 until IDLE.
